bcd5421_frame_dec: RTL and testbench
====================================

# bcd5421_frame_dec

Sequential decoder for the soda machine's 5421-coded digit stream. Each digit is 0–4 as 0000–0100 and 5–9 as 1000–1100; 1111 is the out-of-range marker. The block accepts a fixed-length frame of coded digits, most significant digit first, over a valid/ready handshake. It validates and decodes each digit, builds the binary value of the frame, and presents it downstream (credit or price compare logic) with an error flag and a running error count.

## Interface
- DIGITS, default 2: digits per frame; legal range 1..3.
- OUT_W, default 7: width of the binary result. Must satisfy 2^OUT_W ≥ 10^DIGITS (7 for 2 digits, 10 for 3).
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- clr  input  1  synchronous frame abort; highest priority after reset.
- in_valid  input  1  in_code holds a digit.
- in_ready  output  1  block can accept a digit. Combinational from state: 1 in COLLECT, 0 in HOLD.
- in_code  input  4  5421-coded digit.
- out_valid  output  1  frame result available; registered.
- out_ready  input  1  downstream accepts the result.
- out_value  output  OUT_W  binary value of the frame; registered.
- out_err  output  1  the frame contained at least one invalid code; registered.
- err_cnt  output  8  number of frames with an error; saturates at 255.

## Operation
- States: COLLECT and HOLD. Internal state: digit counter dcnt (0..DIGITS-1), accumulator acc[OUT_W-1:0], and a sticky frame error bit ferr.
- Digit accept: in_valid & in_ready on a rising edge.
- Decode rules:
  - 0000–0100 gives d = code.
  - 1000–1100 gives d = code − 3.
  - Every other code (0101, 0110, 0111, 1101, 1110, 1111) is invalid: d = 0 and ferr is set.
- On each accept in COLLECT: acc ← (acc<<3) + (acc<<1) + d, truncated to OUT_W. With legal OUT_W this never overflows. dcnt increments.
- On the accept where dcnt = DIGITS-1, the block registers:
  - out_value ← the final acc value;
  - out_err ← the final ferr, including the current digit;
  - out_valid ← 1;
  - state ← HOLD;
  - err_cnt increments if out_err is set, saturating at 255.

  In the same edge, acc, dcnt and ferr clear.
- In HOLD:
  - in_ready = 0 and in_valid is ignored.
  - out_valid, out_value and out_err hold stable until out_ready = 1.
  - On the edge with out_ready = 1: out_valid ← 0 and state ← COLLECT. out_value and out_err keep their last value.
- clr = 1 on an edge: state ← COLLECT; acc, dcnt, ferr and out_valid clear. err_cnt and out_value are unchanged. A digit presented on that edge is dropped.
- Asynchronous reset while rst_n = 0:
  - state = COLLECT;
  - acc = 0, dcnt = 0, ferr = 0;
  - out_valid = 0, out_value = 0, out_err = 0, err_cnt = 0.

  It takes effect immediately, without waiting for a clock, and cancels any frame in progress or any pending result.

## Timing
- Reset values: out_valid 0, out_value 0, out_err 0, err_cnt 0, in_ready 1.
- Latency: the last digit is accepted at edge N, and out_valid/out_value are valid from edge N and visible during cycle N+1.
- Throughput: with in_valid and out_ready held high, one frame every DIGITS+1 cycles. The HOLD cycle is a mandatory gap, because in_ready = 0 in HOLD.
- out_ready high before out_valid rises: the result is still held for exactly one cycle.
- clr and out_ready together in HOLD: clr wins, and the outcome is identical (out_valid drops).
- clr together with the final digit: the frame is discarded and no out_valid is produced.
- in_valid may drop between digits. The frame resumes with no timeout.

## Test plan
- Reset with rst_n low and no clock running: out_valid 0, out_value 0, out_err 0, err_cnt 0, in_ready 1. Release, and behaviour stays idle.
- in_code 1010 then 0011 on consecutive cycles, out_ready = 1: out_valid is high for exactly one cycle with out_value 73 and out_err 0. in_ready is 0 during that cycle, and the next frame is accepted right after.
- in_code 0110 then 1100: out_value 9, out_err 1, err_cnt 1. A following frame 1111, 1111 gives out_value 0, out_err 1, err_cnt 2.
- Frame 0100, 1000 with out_ready held 0 for 5 cycles while in_valid toggles: out_valid stays 1, out_value stays 45, and no digit is consumed. When out_ready rises, out_valid drops on that edge.
- Accept 1011, pulse clr, then send 0001, 0010: the 8 is discarded and out_value is 12. Pulsing clr in HOLD drops out_valid and leaves err_cnt unchanged.
- Drive 256 error frames: err_cnt saturates at 255. Assert rst_n low mid-frame and during HOLD: all outputs clear asynchronously, then the next two digits form a fresh frame.

Source files
------------

// File: rtl/bcd5421_frame_dec_if.sv
// bcd5421_frame_dec_if: digit-in / frame-result-out handshake bundle for the 5421 frame decoder.
interface bcd5421_frame_dec_if #(
   parameter int OUT_W = 7
);
   logic             in_valid;
   logic             in_ready;
   logic [3:0]       in_code;
   logic             out_valid;
   logic             out_ready;
   logic [OUT_W-1:0] out_value;
   logic             out_err;
   logic [7:0]       err_cnt;

   modport master (
      output in_valid, in_code, out_ready,
      input  in_ready, out_valid, out_value, out_err, err_cnt
   );

   modport slave (
      input  in_valid, in_code, out_ready,
      output in_ready, out_valid, out_value, out_err, err_cnt
   );
endinterface

// File: rtl/bcd5421_frame_dec.sv
// bcd5421_frame_dec: collects DIGITS 5421-coded digits (MSD first) into a binary value,
// flags frames containing invalid codes and counts them (saturating at 255).
module bcd5421_frame_dec #(
   parameter int DIGITS = 2,
   parameter int OUT_W  = 7
) (
   input logic                clk,
   input logic                rst_n,
   input logic                clr,
   bcd5421_frame_dec_if.slave bus
);
   localparam int CW = DIGITS > 1 ? $clog2(DIGITS) : 1;

   typedef enum logic {COLLECT, HOLD} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    dcnt_q, dcnt_d;
   logic [OUT_W-1:0] acc_q, acc_d;
   logic             ferr_q, ferr_d;
   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_value_q, out_value_d;
   logic             out_err_q, out_err_d;
   logic [7:0]       err_cnt_q, err_cnt_d;

   logic             bad;
   logic [3:0]       dig;
   logic [OUT_W-1:0] acc_nx;
   logic             last;
   logic             accept;

   // Low three bits above 4 are exactly the six illegal codes in both halves.
   always_comb begin
      bad    = bus.in_code[2:0] > 3'd4;
      dig    = bad ? 4'd0 : (bus.in_code[3] ? bus.in_code - 4'd3 : bus.in_code);
      acc_nx = (acc_q << 3) + (acc_q << 1) + OUT_W'(dig);
      last   = dcnt_q == CW'(DIGITS - 1);
      accept = state_q == COLLECT && bus.in_valid;
   end

   always_comb begin
      state_d     = state_q;
      dcnt_d      = dcnt_q;
      acc_d       = acc_q;
      ferr_d      = ferr_q;
      out_valid_d = out_valid_q;
      out_value_d = out_value_q;
      out_err_d   = out_err_q;
      err_cnt_d   = err_cnt_q;
      if (clr) begin
         state_d     = COLLECT;
         dcnt_d      = '0;
         acc_d       = '0;
         ferr_d      = 1'b0;
         out_valid_d = 1'b0;
      end else if (accept && last) begin
         state_d     = HOLD;
         dcnt_d      = '0;
         acc_d       = '0;
         ferr_d      = 1'b0;
         out_valid_d = 1'b1;
         out_value_d = acc_nx;
         out_err_d   = ferr_q | bad;
         err_cnt_d   = (ferr_q | bad) && err_cnt_q != 8'hFF ? err_cnt_q + 8'd1 : err_cnt_q;
      end else if (accept) begin
         dcnt_d = dcnt_q + CW'(1);
         acc_d  = acc_nx;
         ferr_d = ferr_q | bad;
      end else if (state_q == HOLD && bus.out_ready) begin
         state_d     = COLLECT;
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= COLLECT;
         dcnt_q      <= '0;
         acc_q       <= '0;
         ferr_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_value_q <= '0;
         out_err_q   <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         dcnt_q      <= dcnt_d;
         acc_q       <= acc_d;
         ferr_q      <= ferr_d;
         out_valid_q <= out_valid_d;
         out_value_q <= out_value_d;
         out_err_q   <= out_err_d;
         err_cnt_q   <= err_cnt_d;
      end
   end

   assign bus.in_ready  = state_q == COLLECT;
   assign bus.out_valid = out_valid_q;
   assign bus.out_value = out_value_q;
   assign bus.out_err   = out_err_q;
   assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_bcd5421_frame_dec.sv
// tb_bcd5421_frame_dec: directed and random frames against a digit-list reference model,
// checked every falling edge, plus literal expectations from hand-decoded frames.
module tb_bcd5421_frame_dec;
   localparam int DIGITS = 2;
   localparam int OUT_W  = 7;

   logic clk;
   logic rst_n;
   logic clr;

   bcd5421_frame_dec_if #(.OUT_W(OUT_W)) bus ();

   bcd5421_frame_dec #(.DIGITS(DIGITS), .OUT_W(OUT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .bus   (bus.slave)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: frame digits kept as a list, value formed by place weights.
   int m_q[$];
   bit m_bad;
   bit m_vld;
   int m_val;
   bit m_err;
   int m_cnt;

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int decode(input int code, output bit bad);
      bad = 0;
      if (code <= 4) return code;
      if (code >= 8 && code <= 12) return code - 3;
      bad = 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_q.delete();
      m_bad = 0;
      m_vld = 0;
      m_val = 0;
      m_err = 0;
      m_cnt = 0;
   endtask

   task automatic model_step(input bit cl, input bit v, input int code, input bit r);
      int d, w;
      bit b;
      if (cl) begin
         m_q.delete();
         m_bad = 0;
         m_vld = 0;
      end else if (!m_vld && v) begin
         d = decode(code, b);
         m_q.push_back(d);
         m_bad |= b;
         if (m_q.size() == DIGITS) begin
            m_val = 0;
            w = 1;
            for (int i = DIGITS - 1; i >= 0; i--) begin
               m_val += m_q[i] * w;
               w *= 10;
            end
            m_err = m_bad;
            if (m_bad && m_cnt < 255) m_cnt++;
            m_vld = 1;
            m_q.delete();
            m_bad = 0;
         end
      end else if (m_vld && r) begin
         m_vld = 0;
      end
   endtask

   task automatic step(input bit v, input logic [3:0] code, input bit r, input bit cl);
      bus.in_valid  = v;
      bus.in_code   = code;
      bus.out_ready = r;
      clr           = cl;
      @(posedge clk);
      model_step(cl, v, int'(code), r);
      #1;
   endtask

   task automatic chk_out(input string name, input int vld, input int val, input int err, input int cnt);
      chk({name, ".valid"}, int'(bus.out_valid), vld);
      chk({name, ".value"}, int'(bus.out_value), val);
      chk({name, ".err"},   int'(bus.out_err),   err);
      chk({name, ".cnt"},   int'(bus.err_cnt),   cnt);
   endtask

   task automatic async_reset();
      #1 rst_n = 0;
      #1;
      chk_out("async_rst", 0, 0, 0, 0);
      chk("async_rst.in_ready", int'(bus.in_ready), 1);
      model_reset();
      #1 rst_n = 1;
   endtask

   initial begin
      clk = 0;
      #20;
      forever #5 clk = ~clk;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("cyc.in_ready", int'(bus.in_ready), int'(!m_vld));
         chk("cyc.out_valid", int'(bus.out_valid), int'(m_vld));
         chk("cyc.out_value", int'(bus.out_value), m_val);
         chk("cyc.out_err", int'(bus.out_err), int'(m_err));
         chk("cyc.err_cnt", int'(bus.err_cnt), m_cnt);
      end
   end

   initial begin
      rst_n         = 0;
      clr           = 0;
      bus.in_valid  = 0;
      bus.in_code   = '0;
      bus.out_ready = 0;
      model_reset();
      #2;
      chk_out("reset", 0, 0, 0, 0);
      chk("reset.in_ready", int'(bus.in_ready), 1);
      #10 rst_n = 1;
      repeat (3) step(0, 4'b0000, 0, 0);
      chk_out("idle", 0, 0, 0, 0);

      step(1, 4'b1010, 1, 0);
      step(1, 4'b0011, 1, 0);
      chk_out("f73", 1, 73, 0, 0);
      chk("f73.in_ready", int'(bus.in_ready), 0);
      step(1, 4'b0001, 1, 0);
      chk("f73.one_cycle", int'(bus.out_valid), 0);

      step(1, 4'b0110, 1, 0);
      chk_out("f9_mid", 0, 73, 0, 0);
      step(1, 4'b1100, 1, 0);
      chk_out("f9", 1, 9, 1, 1);
      step(0, 4'b0000, 1, 0);
      step(1, 4'b1111, 1, 0);
      step(1, 4'b1111, 1, 0);
      chk_out("f0", 1, 0, 1, 2);
      step(0, 4'b0000, 1, 0);

      step(1, 4'b0100, 0, 0);
      step(1, 4'b1000, 0, 0);
      for (int i = 0; i < 5; i++) begin
         step(i[0], 4'b0001, 0, 0);
         chk_out("f45_hold", 1, 45, 0, 2);
      end
      step(0, 4'b0000, 1, 0);
      chk("f45.drop", int'(bus.out_valid), 0);

      step(1, 4'b1011, 1, 0);
      step(0, 4'b0000, 1, 1);
      step(1, 4'b0001, 1, 0);
      step(1, 4'b0010, 0, 0);
      chk_out("f12", 1, 12, 0, 2);
      step(0, 4'b0000, 1, 1);
      chk_out("clr_hold", 0, 12, 0, 2);

      step(1, 4'b0011, 0, 0);
      step(1, 4'b0100, 0, 1);
      chk_out("clr_last", 0, 12, 0, 2);

      for (int i = 0; i < 256; i++) begin
         step(1, 4'b1101, 1, 0);
         step(1, 4'b0010, 1, 0);
         step(0, 4'b0000, 1, 0);
      end
      chk_out("sat", 0, 2, 1, 255);

      step(1, 4'b1001, 0, 0);
      async_reset();
      step(1, 4'b0010, 0, 0);
      step(1, 4'b0100, 0, 0);
      chk_out("rst_mid", 1, 24, 0, 0);
      async_reset();
      chk("rst_hold.in_ready", int'(bus.in_ready), 1);
      step(1, 4'b1100, 1, 0);
      step(1, 4'b1000, 1, 0);
      chk_out("rst_hold", 1, 95, 0, 0);

      for (int i = 0; i < 400; i++) begin
         logic [3:0] c;
         c = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) :
             ($urandom_range(0, 1) ? 4'($urandom_range(0, 4)) : 4'($urandom_range(8, 12)));
         step(1'($urandom_range(0, 3) != 0), c, 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 19) == 0));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
